// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared arbiter state encoding and rotate-priority helpers
package mux_arb_pkg;

    localparam int MAX_N = 64;
    localparam int IDX_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // One-hot vector with bit idx set; out-of-range indices give all zeros.
    function automatic logic [MAX_N-1:0] onehot(input int idx, input int n);
        logic [MAX_N-1:0] v;
        v = '0;
        if (idx >= 0 && idx < n && idx < MAX_N) begin
            v[idx[IDX_W-1:0]] = 1'b1;
        end
        return v;
    endfunction

    // First set request scanning ptr+1, ptr+2, ... modulo n.
    function automatic pick_t rr_pick(input logic [MAX_N-1:0] req, input int ptr, input int n);
        pick_t p;
        int    c;
        p.found = 1'b0;
        p.idx   = '0;
        for (int k = 1; k <= MAX_N; k++) begin
            if (k <= n && !p.found) begin
                c = (ptr + k) % n;
                if (req[c[IDX_W-1:0]]) begin
                    p.found = 1'b1;
                    p.idx   = c[IDX_W-1:0];
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// rtl/rr_prio_pick.sv - combinational rotate-priority encoder (req, ptr -> found, idx)
module rr_prio_pick
    import mux_arb_pkg::*;
#(
    parameter  int N     = 8,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [MAX_N-1:0] req_ext;
    pick_t            p;
    logic             unused_idx_fold;

    // Widen the request vector to the helper width and pick the next requester after ptr.
    always_comb begin
        req_ext          = '0;
        req_ext[N-1:0]   = req;
        p                = rr_pick(req_ext, int'(ptr), N);
        found            = p.found;
        idx              = p.idx[SEL_W-1:0];
        unused_idx_fold  = ^p.idx;
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter driving a param_mux select (optional MUX_RR_ARB_HOLD_LIMIT_EN)
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter  int N        = 8,
    parameter  int MAX_HOLD = 4,
    localparam int SEL_W    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid,
    output logic             busy
);

    arb_state_e       state;
    logic [SEL_W-1:0] ptr;
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic [MAX_N-1:0] oh_wide;
    logic             unused_oh_fold;
    logic             drop_grant;

`ifdef MUX_RR_ARB_HOLD_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    logic [CNT_W-1:0] hold_cnt;
`endif

    rr_prio_pick #(.N(N)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // One-hot form of the candidate owner, loaded into gnt on a new grant.
    always_comb begin
        oh_wide        = onehot(int'(pick_idx), N);
        unused_oh_fold = ^oh_wide;
    end

    // The owner gives up the grant when it drops req, or when its hold budget is spent.
    always_comb begin
        drop_grant = ~req[sel];
`ifdef MUX_RR_ARB_HOLD_LIMIT_EN
        if (hold_cnt == CNT_W'(MAX_HOLD)) begin
            drop_grant = 1'b1;
        end
`endif
    end

    // IDLE arbitrates, GRANT holds the owner, TURN is a one-cycle gap before rearbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            sel       <= '0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            ptr       <= SEL_W'(N - 1);
`ifdef MUX_RR_ARB_HOLD_LIMIT_EN
            hold_cnt  <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        state     <= ST_GRANT;
                        gnt       <= oh_wide[N-1:0];
                        sel       <= pick_idx;
                        sel_valid <= 1'b1;
                        busy      <= 1'b1;
                        ptr       <= pick_idx;
`ifdef MUX_RR_ARB_HOLD_LIMIT_EN
                        hold_cnt  <= CNT_W'(1);
`endif
                    end
                end
                ST_GRANT: begin
                    if (drop_grant) begin
                        state     <= ST_TURN;
                        gnt       <= '0;
                        sel_valid <= 1'b0;
                    end
`ifdef MUX_RR_ARB_HOLD_LIMIT_EN
                    else if (hold_cnt != CNT_W'(MAX_HOLD)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
`endif
                end
                ST_TURN: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    gnt       <= '0;
                    sel_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - self-checking bench for mux_rr_arbiter
module tb_mux_rr_arbiter;

    localparam int N        = 8;
    localparam int MAX_HOLD = 4;
    localparam int SEL_W    = 3;
`ifdef MUX_RR_ARB_HOLD_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic [SEL_W-1:0] sel;
    logic             sel_valid;
    logic             busy;
    logic [N-1:0]     data_i;
    logic             y;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: owner index (-1 = none), turn-gap flag, last granted index.
    int m_owner, m_last, m_sel, m_held;
    bit m_turn;

    mux_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .sel_valid (sel_valid),
        .busy      (busy)
    );

    assign y = data_i[sel];

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       sv;
        logic       busy;
    } vec_t;

    vec_t tbl[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_turn  = 1'b0;
        m_last  = N - 1;
        m_sel   = 0;
        m_held  = 0;
    endfunction

    function automatic void model_step(input logic [N-1:0] r);
        int c;
        if (m_owner >= 0) begin
            if (!r[m_owner[2:0]] || (LIMIT_EN && m_held == MAX_HOLD)) begin
                m_owner = -1;
                m_turn  = 1'b1;
            end else if (m_held < MAX_HOLD) begin
                m_held++;
            end
        end else if (m_turn) begin
            m_turn = 1'b0;
        end else begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (m_owner < 0 && r[c[2:0]]) begin
                    m_owner = c;
                    m_last  = c;
                    m_sel   = c;
                    m_held  = 1;
                end
            end
        end
    endfunction

    task automatic check_model(input string tag);
        logic [N-1:0] eg;
        eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        check({tag, "/gnt"},  32'(gnt),       32'(eg));
        check({tag, "/sel"},  32'(sel),       32'(m_sel));
        check({tag, "/sv"},   32'(sel_valid), 32'(m_owner >= 0));
        check({tag, "/busy"}, 32'(busy),      32'(m_owner >= 0 || m_turn));
        check({tag, "/oh0"},  32'($onehot0(gnt)), 32'd1);
        check({tag, "/gnt_sv"}, 32'(gnt != '0), 32'(sel_valid));
        if (sel_valid) check({tag, "/y"}, 32'(y), 32'(data_i[m_sel[2:0]]));
    endtask

    task automatic tick(input logic [N-1:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [N-1:0] r);
        rst_n = 1'b0;
        req   = r;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst/gnt",  32'(gnt),       32'd0);
        check("rst/sel",  32'(sel),       32'd0);
        check("rst/sv",   32'(sel_valid), 32'd0);
        check("rst/busy", 32'(busy),      32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] r;
        data_i = 8'hA5;
        rst_n  = 1'b0;
        req    = '0;
        @(negedge clk);

        // Reset with every requester active: requester 0 wins first.
        do_reset(8'hFF);
        tick(8'hFF);
        check("first/gnt", 32'(gnt), 32'h01);
        check("first/sel", 32'(sel), 32'd0);
        check("first/sv",  32'(sel_valid), 32'd1);

        // Directed vectors: owner release, turn gap, wrap-around of the pointer.
        tbl[0]  = '{8'h24, 8'h04, 3'd2, 1'b1, 1'b1};
        tbl[1]  = '{8'h24, 8'h04, 3'd2, 1'b1, 1'b1};
        tbl[2]  = '{8'h24, 8'h04, 3'd2, 1'b1, 1'b1};
        tbl[3]  = '{8'h20, 8'h00, 3'd2, 1'b0, 1'b1};
        tbl[4]  = '{8'h20, 8'h00, 3'd2, 1'b0, 1'b0};
        tbl[5]  = '{8'h20, 8'h20, 3'd5, 1'b1, 1'b1};
        tbl[6]  = '{8'h00, 8'h00, 3'd5, 1'b0, 1'b1};
        tbl[7]  = '{8'h04, 8'h00, 3'd5, 1'b0, 1'b0};
        tbl[8]  = '{8'h04, 8'h04, 3'd2, 1'b1, 1'b1};
        tbl[9]  = '{8'h00, 8'h00, 3'd2, 1'b0, 1'b1};
        tbl[10] = '{8'h80, 8'h00, 3'd2, 1'b0, 1'b0};
        tbl[11] = '{8'h80, 8'h80, 3'd7, 1'b1, 1'b1};
        tbl[12] = '{8'h01, 8'h00, 3'd7, 1'b0, 1'b1};
        tbl[13] = '{8'h01, 8'h00, 3'd7, 1'b0, 1'b0};
        tbl[14] = '{8'h01, 8'h01, 3'd0, 1'b1, 1'b1};
        tbl[15] = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b1};
        tbl[16] = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        do_reset(8'h00);
        for (int i = 0; i < 17; i++) begin
            tick(tbl[i].req);
            check($sformatf("vec%0d/gnt", i),  32'(gnt),       32'(tbl[i].gnt));
            check($sformatf("vec%0d/sel", i),  32'(sel),       32'(tbl[i].sel));
            check($sformatf("vec%0d/sv", i),   32'(sel_valid), 32'(tbl[i].sv));
            check($sformatf("vec%0d/busy", i), 32'(busy),      32'(tbl[i].busy));
        end

        // Two requesters held high constantly.
        do_reset(8'h03);
`ifdef MUX_RR_ARB_HOLD_LIMIT_EN
        for (int i = 0; i < 4; i++) begin tick(8'h03); check("hold/a", 32'(gnt), 32'h01); end
        for (int i = 0; i < 2; i++) begin tick(8'h03); check("hold/gap1", 32'(gnt), 32'h00); end
        for (int i = 0; i < 4; i++) begin tick(8'h03); check("hold/b", 32'(gnt), 32'h02); end
        for (int i = 0; i < 2; i++) begin tick(8'h03); check("hold/gap2", 32'(gnt), 32'h00); end
        tick(8'h03);
        check("hold/a2", 32'(gnt), 32'h01);
`else
        for (int i = 0; i < 16; i++) begin tick(8'h03); check("hold/forever", 32'(gnt), 32'h01); end
`endif

        // Asynchronous reset in the middle of a grant to requester 3.
        do_reset(8'h08);
        tick(8'h08);
        check("mid/gnt", 32'(gnt), 32'h08);
        check("mid/sel", 32'(sel), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("async/gnt",  32'(gnt),       32'd0);
        check("async/sel",  32'(sel),       32'd0);
        check("async/sv",   32'(sel_valid), 32'd0);
        check("async/busy", 32'(busy),      32'd0);
        model_reset();
        req = 8'h09;
        @(negedge clk);
        rst_n = 1'b1;
        tick(8'h09);
        check("after_rst/gnt", 32'(gnt), 32'h01);
        check("after_rst/sel", 32'(sel), 32'd0);

        // Randomized requests against the reference model.
        do_reset(8'h00);
        r = '0;
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(3))
                0: r = N'($urandom);
                1: r = N'($urandom & $urandom);
                default: r = r;
            endcase
            tick(r);
            check_model($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
